periph_bus_arbiter: RTL and testbench

//  Two-master, one-slave arbiter for the native peripheral memory bus
//  (valid/addr/wdata/wstrb/rdata/ready) in front of the GPIO register block.

---
 rtl/periph_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_periph_bus_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
`default_nettype none
//============================================================================
// Module   : periph_bus_arbiter
// Brief    : Two-master round-robin arbiter with hang watchdog for the native
//            peripheral memory bus in front of the GPIO register block.
// Revision : 1.0 - initial release
//============================================================================
module periph_bus_arbiter #(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   output logic [1:0]  grant,
   output logic        timeout_err
);

   localparam int            CW        = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] c_cnt_max = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_last_grant;
   logic [CW-1:0]   r_cnt;

   logic            w_gnt;
   logic            w_sel;
   logic            w_own_valid;
   logic            w_done;
   logic            w_timeout;
   logic            w_abort;
   logic            w_resp;
   logic [31:0]     w_rdata;

   // Gating with rst_n keeps every output quiet while reset is held.
   always_comb begin
      w_gnt       = (r_state != IDLE) && rst_n;
      w_sel       = (r_state == GNT1);
      w_own_valid = w_sel ? m1_valid : m0_valid;
      w_abort     = w_gnt && !w_own_valid;
      w_done      = w_gnt && w_own_valid && s_ready;
      w_timeout   = w_gnt && w_own_valid && !s_ready && (r_cnt == c_cnt_max);
      w_resp      = w_done || w_timeout;
      w_rdata     = w_timeout ? ERR_DATA : s_rdata;
   end

   always_comb begin
      s_valid     = w_gnt && w_own_valid && !w_timeout;
      s_addr      = w_gnt ? (w_sel ? m1_addr  : m0_addr)  : 32'd0;
      s_wdata     = w_gnt ? (w_sel ? m1_wdata : m0_wdata) : 32'd0;
      s_wstrb     = w_gnt ? (w_sel ? m1_wstrb : m0_wstrb) : 4'd0;
      m0_ready    = w_resp && !w_sel;
      m1_ready    = w_resp && w_sel;
      m0_rdata    = m0_ready ? w_rdata : 32'd0;
      m1_rdata    = m1_ready ? w_rdata : 32'd0;
      grant       = {w_gnt && w_sel, w_gnt && !w_sel};
      timeout_err = w_timeout;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (m0_valid && m1_valid)
                  r_state <= r_last_grant ? GNT0 : GNT1;
               else if (m0_valid)
                  r_state <= GNT0;
               else if (m1_valid)
                  r_state <= GNT1;
            end
            GNT0, GNT1: begin
               // A dropped request abandons the grant without touching fairness.
               if (w_abort) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (w_resp) begin
                  r_state      <= IDLE;
                  r_cnt        <= '0;
                  r_last_grant <= w_sel;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_periph_bus_arbiter
// Brief    : Self-checking bench for periph_bus_arbiter with a memory slave stub.
// Revision : 1.0 - initial release
//============================================================================
module tb_periph_bus_arbiter;

   localparam logic [31:0] DDRD = 32'h0000_0008;
   localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
   localparam int          TO   = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ready, m1_ready;
   logic        s_valid;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic [31:0] s_rdata;
   logic        s_ready;
   logic [1:0]  grant;
   logic        timeout_err;

   always #5 clk = ~clk;

   periph_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_rdata(s_rdata), .s_ready(s_ready),
      .grant(grant), .timeout_err(timeout_err)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Slave stub: word memory answering lat cycles after the grant starts.
   logic [31:0] mem [16] = '{default: 32'h0};
   int          slv_cnt = 0;
   int          dir_lat = 0;
   int          rnd_lat = 0;
   logic        rand_lat = 1'b0;
   logic        force_rdy = 1'b0;

   always @(posedge clk) begin
      int r;
      if (s_valid && s_ready && s_wstrb != 4'd0)
         mem[s_addr[5:2]] <= merge(mem[s_addr[5:2]], s_wdata, s_wstrb);
      slv_cnt <= (grant != 2'b00 && !s_ready) ? slv_cnt + 1 : 0;
      if (rand_lat && grant == 2'b00) begin
         r = $urandom_range(0, 9);
         rnd_lat <= (r < 8) ? (r % 4) : ((r == 8) ? 15 : 99);
      end
   end

   always @(negedge clk) begin
      if (force_rdy || (grant != 2'b00 && slv_cnt == (rand_lat ? rnd_lat : dir_lat))) begin
         s_ready <= 1'b1;
         s_rdata <= mem[s_addr[5:2]];
      end else begin
         s_ready <= 1'b0;
         s_rdata <= 32'hA5A5_5A5A;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk); #1;
   endtask

   task automatic drive(input int m, input logic v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st);
      if (m == 0) begin
         m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = st;
      end else begin
         m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = st;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   // One complete transaction from master m; reports what the first grant cycle looked like.
   task automatic run_txn(input int m, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output logic [1:0] fg, output logic [3:0] fst,
                          output logic fsv, output logic [31:0] rd, output int ncyc,
                          output logic to);
      logic done;
      fg = 2'b00; fst = 4'd0; fsv = 1'b0; rd = 32'd0; ncyc = 0; to = 1'b0; done = 1'b0;
      tick();
      drive(m, 1'b1, a, wd, st);
      for (int i = 0; i < 40 && !done; i++) begin
         smp();
         if (grant != 2'b00) begin
            ncyc++;
            if (ncyc == 1) begin fg = grant; fst = s_wstrb; fsv = s_valid; end
         end
         if ((m == 0) ? m0_ready : m1_ready) begin
            done = 1'b1;
            rd   = (m == 0) ? m0_rdata : m1_rdata;
            to   = timeout_err;
         end
         if (!done) tick();
      end
      tick();
      drive(m, 1'b0, a, wd, st);
      if (!done) check("txn_completion_bound", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic       v0, v1;
      logic [1:0] exp_grant;
      logic       exp_r0, exp_r1;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got timeout expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t        vecs[8];
      logic [1:0]  fg;
      logic [3:0]  fst;
      logic        fsv, to;
      logic [31:0] rd;
      int          ncyc;
      int          order[8];
      int          nord, c0, c1;
      logic [31:0] ref_mem[16];
      logic        mv[2], done_seen[2];
      logic [31:0] ma[2], mw[2];
      logic [3:0]  ms[2];
      logic [1:0]  prev_g, exp_g, prev_v;
      logic        prev_done, done, exp_to, normal;
      int          last_done, gcyc, owner;

      vecs[0] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0};

      rst_n = 1'b0;
      drive(0, 1'b1, DDRD, 32'd0, 4'd0);
      drive(1, 1'b0, 32'd0, 32'd0, 4'd0);

      // Reset held with a pending request: every output stays low.
      repeat (10) tick();
      smp();
      check("reset_grant", grant, 2'b00);
      check("reset_s_valid", s_valid, 1'b0);
      check("reset_m0_ready", m0_ready, 1'b0);
      check("reset_m1_ready", m1_ready, 1'b0);
      check("reset_timeout_err", timeout_err, 1'b0);
      tick();
      rst_n = 1'b1;
      drive(0, 1'b0, 32'd0, 32'd0, 4'd0);

      // m0 writes DDRD, m1 reads it back.
      dir_lat = 1;
      run_txn(0, DDRD, 32'h0000_00FF, 4'b0001, fg, fst, fsv, rd, ncyc, to);
      check("wr_grant", fg, 2'b01);
      check("wr_s_wstrb", fst, 4'b0001);
      check("wr_s_valid", fsv, 1'b1);
      check("wr_latency", ncyc, 2);
      check("wr_no_timeout", to, 1'b0);
      smp();
      check("wr_single_pulse", m0_ready, 1'b0);
      check("wr_dead_cycle", grant, 2'b00);
      run_txn(1, DDRD, 32'd0, 4'd0, fg, fst, fsv, rd, ncyc, to);
      check("rd_grant", fg, 2'b10);
      check("rd_m1_rdata", rd, 32'h0000_00FF);

      // Both masters held for four transactions each: strict alternation from m0.
      dir_lat = 0;
      tick();
      drive(0, 1'b1, DDRD, 32'd0, 4'd0);
      drive(1, 1'b1, DDRD, 32'd0, 4'd0);
      nord = 0; c0 = 0; c1 = 0;
      for (int i = 0; i < 100 && (c0 < 4 || c1 < 4); i++) begin
         smp();
         if (m0_ready && m1_ready) check("rr_dual_ready", 32'd1, 32'd0);
         if (m0_ready || m1_ready) begin
            if (nord < 8) order[nord] = m1_ready ? 1 : 0;
            nord++;
            if (m0_ready) c0++; else c1++;
         end
         tick();
         if (c0 >= 4) m0_valid = 1'b0;
         if (c1 >= 4) m1_valid = 1'b0;
      end
      check("rr_count", nord, 8);
      for (int i = 0; i < 8 && i < nord; i++)
         check($sformatf("rr_order_%0d", i), order[i], i % 2);

      // Slave answers exactly at the watchdog limit: normal completion wins.
      dir_lat = 15;
      run_txn(0, DDRD, 32'd0, 4'd0, fg, fst, fsv, rd, ncyc, to);
      check("limit_latency", ncyc, TO);
      check("limit_no_err", to, 1'b0);
      check("limit_rdata", rd, 32'h0000_00FF);

      // Slave never answers: watchdog terminates in the 16th grant cycle.
      dir_lat = 99;
      run_txn(0, DDRD, 32'd0, 4'd0, fg, fst, fsv, rd, ncyc, to);
      check("wdog_latency", ncyc, TO);
      check("wdog_err", to, 1'b1);
      check("wdog_rdata", rd, ERR);
      smp();
      check("wdog_idle", grant, 2'b00);
      check("wdog_err_pulse", timeout_err, 1'b0);

      // Reset asserted mid-grant on m1, then m1 retries.
      tick();
      drive(1, 1'b1, DDRD, 32'd0, 4'd0);
      tick(); tick(); tick();
      rst_n = 1'b0;
      smp();
      check("midrst_grant_low", grant, 2'b00);
      check("midrst_no_ready", m1_ready, 1'b0);
      tick();
      rst_n = 1'b1;
      dir_lat = 0;
      smp();
      check("midrst_idle", grant, 2'b00);
      check("midrst_idle_ready", m1_ready, 1'b0);
      tick();
      smp();
      check("midrst_retry_grant", grant, 2'b10);
      check("midrst_retry_ready", m1_ready, 1'b1);
      check("midrst_retry_rdata", m1_rdata, 32'h0000_00FF);
      tick();
      drive(1, 1'b0, DDRD, 32'd0, 4'd0);

      // Granted master withdraws: no response, fairness pointer untouched.
      dir_lat = 99;
      tick();
      drive(0, 1'b1, DDRD, 32'd0, 4'd0);
      tick(); tick();
      m0_valid = 1'b0;
      smp();
      check("drop_s_valid", s_valid, 1'b0);
      check("drop_no_ready", m0_ready, 1'b0);
      check("drop_no_err", timeout_err, 1'b0);
      tick();
      dir_lat = 0;
      smp();
      check("drop_idle", grant, 2'b00);
      tick();
      m0_valid = 1'b1; m1_valid = 1'b1;
      tick();
      smp();
      check("drop_fair_grant", grant, 2'b01);
      tick();
      m0_valid = 1'b0; m1_valid = 1'b0;

      // Stray s_ready while idle must not produce a response.
      force_rdy = 1'b1;
      tick();
      smp();
      check("idle_rdy_m0", m0_ready, 1'b0);
      check("idle_rdy_m1", m1_ready, 1'b0);
      check("idle_rdy_rdata", m0_rdata, 32'd0);
      check("idle_rdy_grant", grant, 2'b00);
      tick();
      force_rdy = 1'b0;

      // Table: arbitration decisions from a fresh reset.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick();
         m0_valid = vecs[i].v0; m1_valid = vecs[i].v1;
         tick();
         smp();
         check($sformatf("tab%0d_grant", i), grant, vecs[i].exp_grant);
         check($sformatf("tab%0d_r0", i), m0_ready, vecs[i].exp_r0);
         check($sformatf("tab%0d_r1", i), m1_ready, vecs[i].exp_r1);
         tick();
         m0_valid = 1'b0; m1_valid = 1'b0;
      end

      // Randomised traffic against a transaction-level model.
      do_reset();
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      rand_lat = 1'b1;
      mv[0] = 1'b0; mv[1] = 1'b0; done_seen[0] = 1'b0; done_seen[1] = 1'b0;
      ma[0] = 32'd0; ma[1] = 32'd0; mw[0] = 32'd0; mw[1] = 32'd0; ms[0] = 4'd0; ms[1] = 4'd0;
      prev_g = 2'b00; prev_v = 2'b00; prev_done = 1'b0; last_done = 1; gcyc = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick();
         for (int m = 0; m < 2; m++) begin
            if (mv[m] && done_seen[m]) begin
               mv[m] = 1'b0; done_seen[m] = 1'b0;
            end else if (!mv[m] && $urandom_range(0, 2) != 0) begin
               mv[m] = 1'b1;
               ma[m] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
               mw[m] = $urandom;
               ms[m] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
            end
            drive(m, mv[m], ma[m], mw[m], ms[m]);
         end
         smp();
         if (prev_g == 2'b00) begin
            if (prev_v == 2'b00)      exp_g = 2'b00;
            else if (prev_v == 2'b01) exp_g = 2'b01;
            else if (prev_v == 2'b10) exp_g = 2'b10;
            else                      exp_g = (last_done == 0) ? 2'b10 : 2'b01;
         end else begin
            exp_g = prev_done ? 2'b00 : prev_g;
         end
         check("rand_grant", grant, exp_g);
         done = 1'b0;
         if (exp_g != 2'b00) begin
            owner  = exp_g[1] ? 1 : 0;
            gcyc   = (prev_g == 2'b00) ? 1 : gcyc + 1;
            normal = (rnd_lat <= TO - 1) && (gcyc == rnd_lat + 1);
            exp_to = (rnd_lat > TO - 1) && (gcyc == TO);
            done   = normal || exp_to;
            check("rand_ready0", m0_ready, done && owner == 0);
            check("rand_ready1", m1_ready, done && owner == 1);
            check("rand_timeout", timeout_err, exp_to);
            if (done) begin
               check("rand_rdata", (owner == 0) ? m0_rdata : m1_rdata,
                     exp_to ? ERR : ref_mem[ma[owner][5:2]]);
               check("rand_other_rdata", (owner == 0) ? m1_rdata : m0_rdata, 32'd0);
               if (normal && ms[owner] != 4'd0)
                  ref_mem[ma[owner][5:2]] = merge(ref_mem[ma[owner][5:2]], mw[owner], ms[owner]);
               done_seen[owner] = 1'b1;
               last_done = owner;
            end
         end else begin
            check("rand_idle_ready", {m1_ready, m0_ready, timeout_err}, 3'b000);
            check("rand_idle_rdata", m0_rdata | m1_rdata, 32'd0);
         end
         prev_g = exp_g; prev_v = {m1_valid, m0_valid}; prev_done = done;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
